// File: rtl/jt3012_rx.sv
// jt3012_rx: serial DAC-stream receiver turning 13-bit floating-point frames into signed 16-bit samples
// Ports:
//   rst      async active-high reset
//   clk      system clock
//   cen      sampling enable for sy/so/sh1/sh2
//   sy, so   serial shift clock and data (LSB first)
//   sh1, sh2 left/right sample-and-hold strobes
//   left, right         converted signed samples
//   l_valid, r_valid    one-clk update pulses
//   err                 one-clk pulse on a latch edge with a short frame
module jt3012_rx #(
    parameter int SYNC   = 1,
    parameter bit SH_POL = 0
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        sy,
    input  logic        so,
    input  logic        sh1,
    input  logic        sh2,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        l_valid,
    output logic        r_valid,
    output logic        err
);
    // Input pipeline, one bit per pin: {sh2, sh1, so, sy}
    logic [3:0]  stg [0:SYNC];
    logic [3:0]  prev;
    logic [3:0]  cur;
    logic        sy_edge;
    logic        l_latch;
    logic        r_latch;
    logic        latch;
    logic        good;
    logic [12:0] sr;
    logic [3:0]  cnt;
    logic [2:0]  sh_amt;
    logic [15:0] conv;

    assign cur = stg[SYNC];

    always_comb begin
        sy_edge = cen & cur[0] & ~prev[0];
        l_latch = cen & (SH_POL ? (cur[2] & ~prev[2]) : (~cur[2] & prev[2]));
        r_latch = cen & (SH_POL ? (cur[3] & ~prev[3]) : (~cur[3] & prev[3]));
        latch   = l_latch | r_latch;
        good    = cnt >= 4'd13;
        // exponent 0 behaves like exponent 1
        sh_amt  = (sr[12:10] == 3'd0) ? 3'd0 : sr[12:10] - 3'd1;
        // offset-binary mantissa minus 512 is the MSB inverted, then sign-extended
        conv    = {{6{~sr[9]}}, ~sr[9], sr[8:0]} << sh_amt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= SYNC; i++) stg[i] <= '0;
            prev    <= '0;
            sr      <= '0;
            cnt     <= '0;
            left    <= '0;
            right   <= '0;
            l_valid <= 1'b0;
            r_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            l_valid <= l_latch & good;
            r_valid <= r_latch & good;
            err     <= latch & ~good;
            if (cen) begin
                stg[0] <= {sh2, sh1, so, sy};
                for (int i = 1; i <= SYNC; i++) stg[i] <= stg[i-1];
                prev <= cur;
            end
            if (sy_edge) sr <= {cur[1], sr[12:1]};
            // a latch samples the pre-shift frame; a coincident sy edge starts the next one
            if (latch) cnt <= sy_edge ? 4'd1 : 4'd0;
            else if (sy_edge && cnt != 4'd15) cnt <= cnt + 4'd1;
            if (l_latch && good) left <= conv;
            if (r_latch && good) right <= conv;
        end
    end
endmodule

// File: tb/tb_jt3012_rx.sv
// tb_jt3012_rx: randomized and directed checks of jt3012_rx against a bit-queue reference model
module tb_jt3012_rx;
    logic        clk = 0, rst = 1, cen = 0, sy = 0, so = 0, sh1 = 1, sh2 = 1;
    logic [15:0] left, right;
    logic        l_valid, r_valid, err;

    jt3012_rx dut (
        .rst(rst), .clk(clk), .cen(cen), .sy(sy), .so(so), .sh1(sh1), .sh2(sh2),
        .left(left), .right(right), .l_valid(l_valid), .r_valid(r_valid), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    bit cen_off = 0;
    int nl = 0, nr = 0, ne = 0, nboth = 0, nlong = 0;
    logic pl = 0, pr = 0, pe = 0;
    bit q[$];
    logic [15:0] exp_l = 0, exp_r = 0;

    // cen is random but guaranteed at least once every three clocks
    initial begin
        int k = 0;
        forever begin
            @(negedge clk);
            cen = cen_off ? 1'b0 : ((k % 3 == 0) || ($urandom_range(0, 1) == 1));
            k++;
        end
    end

    always @(negedge clk) begin
        if (l_valid) nl++;
        if (r_valid) nr++;
        if (err) ne++;
        if (l_valid && r_valid) nboth++;
        if ((l_valid && pl) || (r_valid && pr) || (err && pe)) nlong++;
        pl = l_valid; pr = r_valid; pe = err;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(bit b);
        so = b;
        wclk(6);
        sy = 1;
        wclk(6);
        sy = 0;
        q.push_back(b);
        wclk(2);
    endtask

    task automatic send_frame(logic [9:0] m, logic [2:0] e);
        logic [12:0] f;
        f = {e, m};
        for (int i = 0; i < 13; i++) send_bit(f[i]);
    endtask

    // value of the last 13 received bits, first of them in bit 0
    function automatic logic [15:0] model_conv();
        int v = 0, m, e, x;
        for (int i = 0; i < 13; i++) v += int'(q[q.size() - 13 + i]) << i;
        m = v % 1024;
        e = v / 1024;
        if (e == 0) e = 1;
        x = (m - 512) * (1 << (e - 1));
        return x[15:0];
    endfunction

    task automatic latch(bit l, bit r, string tag);
        int bl = nl, br = nr, be = ne, bb = nboth;
        bit good = q.size() >= 13;
        logic [15:0] v = good ? model_conv() : 16'h0;
        if (good && l) exp_l = v;
        if (good && r) exp_r = v;
        q.delete();
        if (l) sh1 = 0;
        if (r) sh2 = 0;
        wclk(6);
        sh1 = 1;
        sh2 = 1;
        wclk(20);
        chk({tag, " left"}, left, exp_l);
        chk({tag, " right"}, right, exp_r);
        chk({tag, " l_valid pulses"}, nl - bl, (good && l) ? 1 : 0);
        chk({tag, " r_valid pulses"}, nr - br, (good && r) ? 1 : 0);
        chk({tag, " err pulses"}, ne - be, good ? 0 : 1);
        if (l && r && good) chk({tag, " same-clk valids"}, nboth - bb, 1);
    endtask

    initial begin
        wclk(4);
        chk("rst left", left, 0);
        chk("rst right", right, 0);
        chk("rst pulses", {l_valid, r_valid, err}, 0);
        rst = 0;
        wclk(10);
        chk("post-rst no pulses", nl + nr + ne, 0);

        send_frame(10'h3FF, 3'd7);
        latch(1, 0, "max");
        chk("max value", left, 16'h7FC0);
        send_frame(10'h000, 3'd7);
        latch(0, 1, "min");
        chk("min value", right, 16'h8000);
        send_frame(10'h201, 3'd1);
        latch(1, 0, "one");
        chk("one value", left, 16'h0001);
        send_frame(10'h202, 3'd0);
        latch(0, 1, "e0");
        chk("e0 value", right, 16'h0002);
        send_frame(10'h200, 3'd5);
        latch(1, 0, "zero");
        chk("zero value", left, 16'h0000);

        send_frame(10'h3FF, 3'd7);
        latch(1, 0, "pre-short");
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        latch(1, 0, "short");
        chk("short keeps left", left, 16'h7FC0);
        send_frame(10'h123, 3'd3);
        latch(1, 0, "after-short");

        send_frame(10'h300, 3'd2);
        latch(1, 1, "both");
        chk("both left", left, 16'h0200);
        chk("both right", right, 16'h0200);

        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        send_frame(10'h0F0, 3'd6);
        latch(0, 1, "overlong");

        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)));
        rst = 1;
        wclk(3);
        chk("midrst left", left, 0);
        chk("midrst right", right, 0);
        chk("midrst pulses", {l_valid, r_valid, err}, 0);
        q.delete();
        exp_l = 0;
        exp_r = 0;
        rst = 0;
        wclk(10);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        latch(1, 0, "post-rst short");

        send_frame(10'h155, 3'd4);
        begin
            int bl, br, be;
            cen_off = 1;
            wclk(3);
            bl = nl; br = nr; be = ne;
            repeat (4) begin
                sy = 1; wclk(5); so = ~so; sy = 0; wclk(5);
            end
            sh1 = 0; wclk(10); sh1 = 1;
            sh2 = 0; wclk(10); sh2 = 1;
            so = 0;
            wclk(40);
            chk("cenoff left", left, exp_l);
            chk("cenoff right", right, exp_r);
            chk("cenoff pulses", (nl - bl) + (nr - br) + (ne - be), 0);
            cen_off = 0;
            wclk(10);
        end
        latch(1, 0, "after cenoff");

        for (int t = 0; t < 14; t++) begin
            int lens[5] = '{5, 8, 13, 14, 16};
            int n = lens[$urandom_range(0, 4)];
            int sel = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
            latch(sel[0], sel[1], $sformatf("rand%0d", t));
        end

        chk("single-clk pulses", nlong, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
